yarp_fetch: RTL and testbench

//   Instruction fetch stage of the YARP core, directly upstream of yarp_decode.

---
 rtl/yarp_pkg.sv | 21 ++
 rtl/yarp_fetch.sv | 133 +++++++++++++
 tb/tb_yarp_fetch.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/yarp_pkg.sv
// Shared types and constants for the YARP core.
//   fetch_state_t : fetch stage FSM encoding
//   PC_INCR       : sequential PC step (one 32-bit word)
//   align_word()  : clears the byte-offset bits of an address
package yarp_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT,
        F_HOLD
    } fetch_state_t;

    localparam logic [31:0] PC_INCR = 32'd4;

    // Masking, rather than slicing, keeps every input bit in use.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/yarp_fetch.sv
// YARP instruction fetch stage.
// Holds the PC and issues one word read at a time to instruction memory.
// There is at most one outstanding request. Fetched {instr, pc} pairs go to
// decode over a valid/ready handshake. Execute can redirect the PC.
//   clk, reset_n       : clock, synchronous active-low reset
//   imem_req_o/addr_o  : read request and word-aligned address
//   imem_gnt_i         : request accepted when req & gnt
//   imem_rvalid_i/rdata_i : read response, valid only while waiting
//   instr_valid_o/instr_o/pc_o : fetched instruction toward decode
//   instr_ready_i      : decode consumes the instruction when valid & ready
//   redirect_i/redirect_pc_i : restart fetch at the target (low bits cleared)
module yarp_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    import yarp_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q;
    logic         kill_q;
    logic [31:0]  instr_q;
    logic [31:0]  pc_out_q;
    logic [31:0]  target_pc;

    assign target_pc = align_word(redirect_pc_i);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= F_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            F_IDLE: state_d = F_REQ;
            // An accepted request must be waited out even when redirected;
            // its response is dropped through the kill flag.
            F_REQ: begin
                if (imem_gnt_i) begin
                    state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = (redirect_i || kill_q) ? F_REQ : F_HOLD;
                end
            end
            F_HOLD: begin
                if (redirect_i || instr_ready_i) begin
                    state_d = F_REQ;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    // PC, kill flag and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            instr_q  <= '0;
            pc_out_q <= RESET_PC;
        end else begin
            unique case (state_q)
                F_REQ: begin
                    if (redirect_i) begin
                        pc_q <= target_pc;
                        if (imem_gnt_i) begin
                            kill_q <= 1'b1;
                        end
                    end
                end
                F_WAIT: begin
                    if (imem_rvalid_i) begin
                        kill_q <= 1'b0;
                        if (redirect_i) begin
                            pc_q <= target_pc;
                        end else if (!kill_q) begin
                            instr_q  <= imem_rdata_i;
                            pc_out_q <= pc_q;
                        end
                    end else if (redirect_i) begin
                        kill_q <= 1'b1;
                        pc_q   <= target_pc;
                    end
                end
                F_HOLD: begin
                    if (redirect_i) begin
                        pc_q <= target_pc;
                    end else if (instr_ready_i) begin
                        pc_q <= pc_q + PC_INCR;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        imem_req_o    = (state_q == F_REQ);
        imem_addr_o   = pc_q;
        instr_valid_o = (state_q == F_HOLD);
        instr_o       = instr_q;
        pc_o          = pc_out_q;
    end

    // A response is only legal while a request is outstanding.
    a_rvalid_in_wait : assert property (
        @(posedge clk) disable iff (!reset_n) imem_rvalid_i |-> (state_q == F_WAIT)
    );

endmodule

// File: tb/tb_yarp_fetch.sv
// Directed testbench for yarp_fetch. Drives the memory and decode sides by hand
// and checks outputs one time unit after each rising clock edge.
module tb_yarp_fetch;

    logic        clk;
    logic        reset_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    int unsigned n_cmp;
    int unsigned n_err;

    yarp_fetch #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From REQ: accept, return data one cycle later, land in HOLD.
    task automatic do_fetch(input string tag, input logic [31:0] data, input logic [31:0] exp_pc);
        chk({tag, "_req"}, {31'd0, imem_req_o}, 32'd1);
        chk({tag, "_addr"}, imem_addr_o, exp_pc);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        chk({tag, "_wait_req"}, {31'd0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
        chk({tag, "_instr"}, instr_o, data);
        chk({tag, "_pc"}, pc_o, exp_pc);
    endtask

    // From HOLD: handshake with decode, expect next request at exp_next.
    task automatic consume(input string tag, input logic [31:0] exp_next);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, instr_valid_o}, 32'd0);
        chk({tag, "_next_req"}, {31'd0, imem_req_o}, 32'd1);
        chk({tag, "_next_addr"}, imem_addr_o, exp_next);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;

        repeat (3) tick();
        chk("rst_req",   {31'd0, imem_req_o},    32'd0);
        chk("rst_addr",  imem_addr_o,            32'h0000_0000);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o,                32'h0000_0000);
        chk("rst_pc",    pc_o,                   32'h0000_0000);

        // Release: one idle cycle, then the first request.
        reset_n = 1'b1;
        chk("idle_req", {31'd0, imem_req_o}, 32'd0);
        tick();

        // Test 1: back-to-back sequential fetches.
        do_fetch("t1_f0", 32'h1111_0000, 32'h0000_0000);
        consume("t1_c0", 32'h0000_0004);
        do_fetch("t1_f1", 32'h1111_0004, 32'h0000_0004);
        consume("t1_c1", 32'h0000_0008);
        do_fetch("t1_f2", 32'h1111_0008, 32'h0000_0008);
        consume("t1_c2", 32'h0000_000C);

        // Test 2: grant withheld for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_req_hold",  {31'd0, imem_req_o}, 32'd1);
            chk("t2_addr_hold", imem_addr_o,         32'h0000_000C);
        end
        do_fetch("t2_f", 32'h2222_000C, 32'h0000_000C);

        // Test 3: decode stalls for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("t3_instr", instr_o,                32'h2222_000C);
            chk("t3_pc",    pc_o,                   32'h0000_000C);
            chk("t3_req",   {31'd0, imem_req_o},    32'd0);
        end
        consume("t3_c", 32'h0000_0010);

        // Test 4: redirect while waiting; the stale response is dropped.
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        tick();
        redirect_i    = 1'b0;
        chk("t4_still_wait", {31'd0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        chk("t4_no_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t4_req",      {31'd0, imem_req_o},    32'd1);
        chk("t4_addr",     imem_addr_o,            32'h0000_0100);
        do_fetch("t4_f", 32'h3333_0100, 32'h0000_0100);

        // Test 5: redirect in HOLD with ready asserted in the same cycle.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        instr_ready_i = 1'b1;
        tick();
        redirect_i    = 1'b0;
        instr_ready_i = 1'b0;
        chk("t5_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t5_req",   {31'd0, imem_req_o},    32'd1);
        chk("t5_addr",  imem_addr_o,            32'h0000_0200);

        // Redirect in REQ without grant: address moves, request stays up.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        tick();
        redirect_i = 1'b0;
        chk("rq_redir_req",  {31'd0, imem_req_o}, 32'd1);
        chk("rq_redir_addr", imem_addr_o,         32'h0000_0300);

        // Redirect in REQ with grant: accepted request is killed.
        imem_gnt_i    = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0400;
        tick();
        imem_gnt_i = 1'b0;
        redirect_i = 1'b0;
        chk("rqg_wait", {31'd0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_0300;
        tick();
        imem_rvalid_i = 1'b0;
        chk("rqg_no_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rqg_req",      {31'd0, imem_req_o},    32'd1);
        chk("rqg_addr",     imem_addr_o,            32'h0000_0400);

        // Redirect coinciding with rvalid in WAIT.
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_0400;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0500;
        tick();
        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b0;
        chk("wrv_no_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("wrv_req",      {31'd0, imem_req_o},    32'd1);
        chk("wrv_addr",     imem_addr_o,            32'h0000_0500);

        // Test 6: wrap at the top of the address space; low bits are cleared.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        redirect_i = 1'b0;
        chk("t6_align", imem_addr_o, 32'hFFFF_FFFC);
        do_fetch("t6_f", 32'h4444_FFFC, 32'hFFFF_FFFC);
        consume("t6_wrap", 32'h0000_0000);

        // Reset mid-WAIT with kill set; everything must come back clean.
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0700;
        tick();
        redirect_i = 1'b0;
        reset_n    = 1'b0;
        tick();
        chk("t6r_req",   {31'd0, imem_req_o},    32'd0);
        chk("t6r_addr",  imem_addr_o,            32'h0000_0000);
        chk("t6r_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("t6r_instr", instr_o,                32'h0000_0000);
        chk("t6r_pc",    pc_o,                   32'h0000_0000);
        reset_n = 1'b1;
        tick();
        do_fetch("t6r_f", 32'h5555_0000, 32'h0000_0000);
        consume("t6r_c", 32'h0000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard bound in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
